onchip_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port 32-bit on-chip RAM (16-bit word address, 4-bit byteenable, 1-cycle read latency) between NUM_MASTERS Avalon-MM requesters, e.g. the CPU data master and the DCT block DMA.
- Sits directly in front of the RAM slave port.
- Provides per-master waitrequest and readdatavalid, plus an optional grant-lock for read-modify-write sequences.

---
 rtl/onchip_arb_pkg.sv | 42 ++++
 rtl/onchip_arb_rr_pick.sv | 25 ++
 rtl/onchip_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared state type, sizing constants and the round-robin
// pick function used by the on-chip RAM arbiter.
package onchip_arb_pkg;

  localparam int MAX_MASTERS = 4;
  localparam int BE_W        = 4;
  localparam int IDX_MAX_W   = 2;

  typedef logic [IDX_MAX_W-1:0] idx_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } rr_pick_t;

  // Scans downward so the requester closest to ptr (smallest offset) is the last write.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input idx_t                   ptr,
                                       input int                     n);
    rr_pick_t res;
    int       pos;
    idx_t     sel;
    res = '0;
    for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
      if (k < n) begin
        pos = (int'(ptr) + k) % n;
        sel = pos[IDX_MAX_W-1:0];
        if (req[sel]) begin
          res.valid = 1'b1;
          res.idx   = sel;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/onchip_arb_rr_pick.sv
// onchip_arb_rr_pick: combinational priority rotator; grants the first
// requester at or after ptr, wrapping within NUM_MASTERS.
module onchip_arb_rr_pick
  import onchip_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  idx_t                   ptr,
  output logic                   grant_valid,
  output idx_t                   grant_idx
);

  logic [MAX_MASTERS-1:0] req_ext;
  rr_pick_t               pick;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_MASTERS-1:0] = req;
    pick                     = rr_pick(req_ext, ptr, NUM_MASTERS);
    grant_valid              = pick.valid;
    grant_idx                = pick.idx;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin Avalon-MM arbiter in front of the single-port
// on-chip RAM with grant lock. Define ONCHIP_ARB_STATS_EN for per-master grant counters.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [NUM_MASTERS-1:0]        m_lock,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  output logic                          mem_clken,
`ifdef ONCHIP_ARB_STATS_EN
  input  logic                          stats_clr,
  output logic [NUM_MASTERS*32-1:0]     grant_cnt,
`endif
  input  logic [DATA_W-1:0]             mem_readdata
);

  arb_state_t             state, state_nxt;
  idx_t                   rr_ptr, lock_owner, rd_id, pick_idx, g;
  logic                   pick_valid, grant_valid, rd_pend;
  logic                   owner_req, owner_lock, g_read, g_write, g_lock;
  logic [NUM_MASTERS-1:0] req, sel, gnt;

  assign req       = m_read | m_write;
  assign mem_clken = 1'b1;

  onchip_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_pick (
    .req        (req),
    .ptr        (rr_ptr),
    .grant_valid(pick_valid),
    .grant_idx  (pick_idx)
  );

  // While locked only the owner can be granted, even on the release cycle.
  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (lock_owner == idx_t'(i)) begin
        owner_req  = req[i];
        owner_lock = m_lock[i];
      end
    end

    grant_valid = 1'b0;
    g           = pick_idx;
    if (!reset) begin
      if (state == ARB) begin
        grant_valid = pick_valid;
      end else begin
        grant_valid = owner_req;
        g           = lock_owner;
      end
    end

    sel = '0;
    gnt = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel[i] = (g == idx_t'(i));
      gnt[i] = grant_valid & sel[i];
    end
    g_read  = |(gnt & m_read);
    g_write = |(gnt & m_write);
    g_lock  = |(gnt & m_lock);

    state_nxt = state;
    case (state)
      ARB:     if (grant_valid && g_lock) state_nxt = LOCKED;
      LOCKED:  if (!owner_lock) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel[i]) begin
        mem_address    = m_address[i*ADDR_W +: ADDR_W];
        mem_byteenable = m_byteenable[i*BE_W +: BE_W];
        mem_writedata  = m_writedata[i*DATA_W +: DATA_W];
      end
    end
    m_waitrequest  = ~gnt;
    mem_chipselect = grant_valid;
    mem_write      = g_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      rr_ptr     <= '0;
      lock_owner <= '0;
      rd_pend    <= 1'b0;
      rd_id      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && grant_valid) begin
        rr_ptr <= (g == idx_t'(NUM_MASTERS - 1)) ? '0 : g + idx_t'(1);
        if (g_lock) lock_owner <= g;
      end
      rd_pend <= grant_valid & g_read & ~g_write;
      rd_id   <= g;
    end
  end

  // RAM data lands one cycle after the address; a reset in that cycle drops it.
  always_comb begin
    m_readdatavalid = '0;
    m_readdata      = '0;
    if (rd_pend && !reset) begin
      m_readdata = mem_readdata;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (rd_id == idx_t'(i)) m_readdatavalid[i] = 1'b1;
      end
    end
  end

`ifdef ONCHIP_ARB_STATS_EN
  logic [NUM_MASTERS-1:0][31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (gnt[i] && cnt[i] != 32'hFFFF_FFFF) cnt[i] <= cnt[i] + 32'd1;
      end
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed stimulus with a read-return scoreboard for
// onchip_mem_arbiter (2 masters) driving a behavioural 1-cycle-latency RAM.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_address;
  logic [7:0]  m_byteenable;
  logic [1:0]  m_read, m_write, m_lock;
  logic [63:0] m_writedata;
  logic [1:0]  m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
`ifdef ONCHIP_ARB_STATS_EN
  logic        stats_clr;
  logic [63:0] grant_cnt;
`endif

  logic [31:0] ram [0:65535];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  onchip_mem_arbiter #(
    .NUM_MASTERS(2),
    .ADDR_W     (16),
    .DATA_W     (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m_address      (m_address),
    .m_byteenable   (m_byteenable),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_lock         (m_lock),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
`ifdef ONCHIP_ARB_STATS_EN
    .stats_clr      (stats_clr),
    .grant_cnt      (grant_cnt),
`endif
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Monitor: every read return is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m_readdatavalid !== 2'b00) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL rdv_unexpected: got rdv=%b data=%h at cycle %0d, required no return",
                 m_readdatavalid, m_readdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (m_readdatavalid !== (2'b01 << e.id) || m_readdata !== e.data || cyc != e.due) begin
          n_mismatched++;
          $display("[TB] FAIL rd_return: got rdv=%b data=%h cycle=%0d, required rdv=%b data=%h cycle=%0d",
                   m_readdatavalid, m_readdata, cyc, 2'b01 << e.id, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic        rst,
                               input logic [1:0]  rd, wr, lk,
                               input logic [15:0] a0, a1,
                               input logic [3:0]  be0, be1,
                               input logic [31:0] d0, d1);
    @(posedge clk);
    #1;
    reset        = rst;
    m_read       = rd;
    m_write      = wr;
    m_lock       = lk;
    m_address    = {a1, a0};
    m_byteenable = {be1, be0};
    m_writedata  = {d1, d0};
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic pushExp(input int id, input logic [31:0] data);
    exp_q.push_back('{id: id, data: data, due: cyc + 1});
  endtask

  task automatic checkOutput(input string name, input logic [1:0] exp_wait,
                             input logic exp_cs, input logic exp_wr, input logic [15:0] exp_addr);
    logic [19:0] act, req;
    @(negedge clk);
    act = {m_waitrequest, mem_chipselect, mem_write, exp_cs ? mem_address : 16'h0};
    req = {exp_wait, exp_cs, exp_wr, exp_cs ? exp_addr : 16'h0};
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got wait=%b cs=%b wr=%b addr=%h, required wait=%b cs=%b wr=%b addr=%h",
               name, act[19:18], act[17], act[16], act[15:0], req[19:18], req[17], req[16], req[15:0]);
    end
  endtask

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    reset        = 1'b1;
    m_read       = '0;
    m_write      = '0;
    m_lock       = '0;
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
`ifdef ONCHIP_ARB_STATS_EN
    stats_clr    = 1'b0;
`endif

    // Reset with requests pending: nothing granted, outputs cleared.
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    checkOutput("reset_wait", 2'b11, 1'b0, 1'b0, 16'h0);
    checkEq("reset_rdv_data", {30'h0, m_readdatavalid, m_readdata}, 64'h0);
    checkEq("clken", 64'(mem_clken), 64'h1);
    idle(1'b1);
    checkOutput("reset_idle", 2'b11, 1'b0, 1'b0, 16'h0);

    // Single master write then read-back.
    applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 16'h0010, 16'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0);
    checkOutput("wr_m0", 2'b10, 1'b1, 1'b1, 16'h0010);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 4'hF, 4'h0, 32'h0, 32'h0);
    pushExp(0, 32'hDEADBEEF);
    checkOutput("rd_m0", 2'b10, 1'b1, 1'b0, 16'h0010);
    idle(1'b0);
    checkOutput("idle_m0", 2'b11, 1'b0, 1'b0, 16'h0);

    // Byte enables, then read+write on one master (write wins, no return).
    applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 16'h0020, 16'h0, 4'hF, 4'h0, 32'h11223344, 32'h0);
    checkOutput("wr_full", 2'b10, 1'b1, 1'b1, 16'h0020);
    applyStimulus(1'b0, 2'b00, 2'b10, 2'b00, 16'h0, 16'h0020, 4'h0, 4'b0101, 32'h0, 32'hAABBCCDD);
    checkOutput("wr_be0101", 2'b01, 1'b1, 1'b1, 16'h0020);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 16'h0020, 16'h0, 4'hF, 4'h0, 32'h0, 32'h0);
    pushExp(0, 32'h11BB33DD);
    checkOutput("rd_be", 2'b10, 1'b1, 1'b0, 16'h0020);
    applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 16'h0030, 16'h0, 4'hF, 4'h0, 32'h00000055, 32'h0);
    checkOutput("rw_m0", 2'b10, 1'b1, 1'b1, 16'h0030);
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0030, 4'h0, 4'hF, 32'h0, 32'h0);
    pushExp(1, 32'h00000055);
    checkOutput("rd_m1", 2'b01, 1'b1, 1'b0, 16'h0030);
    checkEq("rw_no_rdv", 64'(m_readdatavalid), 64'h0);
    idle(1'b0);
    checkOutput("idle_be", 2'b11, 1'b0, 1'b0, 16'h0);

    // From reset, both masters read every cycle: 0,1,0,1 with no bubbles.
    idle(1'b1);
    checkOutput("reset2", 2'b11, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
      if (k % 2 == 0) begin
        pushExp(0, 32'hDEADBEEF);
        checkOutput("alt_m0", 2'b10, 1'b1, 1'b0, 16'h0010);
      end else begin
        pushExp(1, 32'h11BB33DD);
        checkOutput("alt_m1", 2'b01, 1'b1, 1'b0, 16'h0020);
      end
    end

    // Master 1 takes the lock, idles while holding it, releases; master 0 wins next.
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b10, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    pushExp(1, 32'h11BB33DD);
    checkOutput("lock_take", 2'b01, 1'b1, 1'b0, 16'h0020);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b10, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    pushExp(1, 32'h11BB33DD);
    checkOutput("lock_hold", 2'b01, 1'b1, 1'b0, 16'h0020);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b10, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    checkOutput("lock_owner_idle", 2'b11, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    pushExp(1, 32'h11BB33DD);
    checkOutput("lock_release", 2'b01, 1'b1, 1'b0, 16'h0020);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    pushExp(0, 32'hDEADBEEF);
    checkOutput("post_lock_m0", 2'b10, 1'b1, 1'b0, 16'h0010);
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    pushExp(1, 32'h11BB33DD);
    checkOutput("post_lock_m1", 2'b01, 1'b1, 1'b0, 16'h0020);

    // Reset right after a granted read: return dropped, pointer back to master 0.
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    checkOutput("rd_before_rst", 2'b10, 1'b1, 1'b0, 16'h0010);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    checkOutput("rst_mid", 2'b11, 1'b0, 1'b0, 16'h0);
    checkEq("rst_drop_rdv", 64'(m_readdatavalid), 64'h0);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 4'hF, 4'hF, 32'h0, 32'h0);
    pushExp(0, 32'hDEADBEEF);
    checkOutput("rst_rr0", 2'b10, 1'b1, 1'b0, 16'h0010);
    idle(1'b0);
    checkOutput("idle_end", 2'b11, 1'b0, 1'b0, 16'h0);

`ifdef ONCHIP_ARB_STATS_EN
    // Five grants to master 1, then a clear that coincides with a sixth.
    idle(1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b10, 2'b00, 16'h0, 16'h0040, 4'h0, 4'hF, 32'h0, 32'(k));
      checkOutput("cnt_wr", 2'b01, 1'b1, 1'b1, 16'h0040);
    end
    applyStimulus(1'b0, 2'b00, 2'b10, 2'b00, 16'h0, 16'h0040, 4'h0, 4'hF, 32'h0, 32'h5);
    stats_clr = 1'b1;
    checkOutput("cnt_wr6", 2'b01, 1'b1, 1'b1, 16'h0040);
    checkEq("cnt_before_clr", 64'(grant_cnt[63:32]), 64'd5);
    idle(1'b0);
    stats_clr = 1'b0;
    checkOutput("cnt_idle", 2'b11, 1'b0, 1'b0, 16'h0);
    checkEq("cnt_after_clr", grant_cnt, 64'h0);
`endif

    idle(1'b0);
    @(negedge clk);
    checkEq("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
